muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit that owns the HI/LO special registers of the single-cycle core.
//  Replaces the combinational 64-bit multiplier with a radix-2 sequencer.
//  Stalls the core when an instruction needs HI/LO, or a new mul/div, while an operation is still running.
//  Sits beside the ALU, fed by srca/srcb; its hi/lo outputs drive the mfhi/mflo result mux.
// PARAMETERS
//  WIDTH   32   operand width; one iteration per bit
// PORTS
//  clk      in   1      clock
//  reset    in   1      synchronous, active-high
//  start    in   1      decoded mult/multu/div/divu in the current instruction
//  op       in   2      00 multu, 01 mult, 10 divu, 11 div
//  srca     in   WIDTH  rs operand (multiplicand / dividend)
//  srcb     in   WIDTH  rt operand (multiplier / divisor)
//  rd_req   in   1      current instruction is mfhi/mflo
//  stall    out  1      freeze PC and suppress regwrite this cycle
//  busy     out  1      operation in flight (RUN or FIX)
//  done     out  1      one-cycle pulse: new hi/lo visible this cycle
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; busy=done=stall=0; iteration counter=0.
//  States:
//   IDLE -> RUN when start=1 (accept edge E0).
//   RUN -> FIX after WIDTH steps.
//   FIX -> IDLE.
//  At E0: latch op, operand sign bits and operand magnitudes.
//   Magnitude = two's-complement abs for signed ops, raw value for unsigned ops.
//  RUN, one step per cycle:
//   mul: shift-add into a 2*WIDTH accumulator.
//   div: restoring shift-subtract producing quotient and remainder.
//  FIX, single cycle:
//   mul: negate the 2*WIDTH product if sign_a^sign_b (signed op).
//   div: negate quotient if sign_a^sign_b; negate remainder if sign_a.
//   Write hi/lo at the edge ending FIX.
//  done=1 in the IDLE cycle following FIX (registered), for exactly 1 cycle.
//  Latency: start at E0 -> done and new hi/lo in cycle WIDTH+2 after E0.
//  hi/lo change only at the FIX-exit edge or on reset; never hold partial results.
//  Arithmetic rules:
//   mul: {hi,lo} = full 2*WIDTH product.
//   div: lo = quotient, hi = remainder.
//   divisor=0: lo = all ones, hi = dividend (before sign fix for signed ops).
//   div 0x80000000 / -1: lo=0x80000000, hi=0.
//  stall = busy & (rd_req | start); combinational. stall is 0 in the done cycle and in IDLE.
//  start while busy: ignored. The core holds the instruction via stall and re-presents it.
//  start in the done cycle: accepted (back-to-back, no bubble).
//  The stall input to the core is undefined if start and rd_req are both 1; this case cannot occur (exclusive decode).
//  reset mid-operation: abort next edge; hi=lo=0; no done pulse.
//  Counter is log2(WIDTH)+1 bits; it never wraps (cleared at E0).
// CONFIGURATION
//  MULDIV_DIV_EN defined: divu/div supported as above.
//  MULDIV_DIV_EN undefined:
//   start with op[1]=1 is ignored: no state change, no busy, no done, hi/lo unchanged.
//   Divider step logic is not synthesized.
// STRUCTURE
//  Package muldiv_pkg: op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV), state encoding (IDLE/RUN/FIX), WIDTH default.
//  Sub-module muldiv_step:
//   Combinational single iteration; inputs: accumulator, operand, mode.
//   Outputs: next accumulator (add-shift for mul, subtract-restore-shift for div).
//  Top level holds the FSM, counter, sign fixup and hi/lo registers.
// TESTING
//  multu 0xFFFFFFFF*0xFFFFFFFF -> done at E0+34; hi=0xFFFFFFFE, lo=0x00000001.
//  mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. mult 0*x -> hi=lo=0.
//  div: divu 100/7 -> lo=14, hi=2; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  div by zero: divu 5/0 -> lo=0xFFFFFFFF, hi=5.
//  Stall:
//   mult, then rd_req=1 next cycle -> stall=1 through the FIX cycle, 0 in the done cycle.
//   mflo then reads the new lo.
//   start held during busy -> stall=1; accepted in the done cycle; second done at +34 from that edge.
//  reset asserted on RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse.
//  Without MULDIV_DIV_EN: start with op=10 -> busy stays 0; hi/lo unchanged after 40 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// The divider datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Divide step logic exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]     mul_sum_c;
    logic [2*WIDTH-1:0] mul_next_c;

    // Upper half accumulates the multiplicand; the carry lands in the bit shifted down.
    always_comb begin
        mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next_c = {mul_sum_c, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   div_sh_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_diff_c;

    // Remainder is always below the divisor, so the trial difference fits in WIDTH bits.
    always_comb begin
        div_sh_c   = acc[2*WIDTH-1:WIDTH-1];
        div_ge_c   = div_sh_c >= {1'b0, operand};
        div_diff_c = WIDTH'(div_sh_c - {1'b0, operand});
        acc_next   = mul_next_c;
        if (mode) begin
            if (div_ge_c) begin
                acc_next = {div_diff_c, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;

    always_comb begin
        acc_next = mul_next_c;
    end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit with core stall generation.
// Define MULDIV_DIV_EN to accept divu/div; otherwise those starts are ignored.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rd_req,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q, acc_next_c;
    logic [WIDTH-1:0] opb_q;
    logic             sign_a_q, sign_b_q, is_div_q;

    logic             signed_op_c, div_op_c, accept_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [ACC_W-1:0] prod_c;
    logic [WIDTH-1:0] quo_c, rem_c, fix_hi_c, fix_lo_c;

    // Operand decode and magnitude extraction at the accept edge.
    always_comb begin
        signed_op_c = (op == MD_MULT) || (op == MD_DIV);
        div_op_c    = (op == MD_DIVU) || (op == MD_DIV);
        accept_c    = start && (state_q == IDLE) && (DIV_EN || !div_op_c);
        mag_a_c     = (signed_op_c && srca[WIDTH-1]) ? WIDTH'(-srca) : srca;
        mag_b_c     = (signed_op_c && srcb[WIDTH-1]) ? WIDTH'(-srcb) : srcb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (opb_q),
        .mode     (is_div_q),
        .acc_next (acc_next_c)
    );

    // Sign fixup of the magnitude result, applied during FIX.
    always_comb begin
        prod_c = (sign_a_q ^ sign_b_q) ? ACC_W'(-acc_q) : acc_q;
        quo_c  = (sign_a_q ^ sign_b_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_c  = sign_a_q ? WIDTH'(-acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
        if (is_div_q) begin
            fix_hi_c = rem_c;
            fix_lo_c = quo_c;
        end else begin
            fix_hi_c = prod_c[ACC_W-1:WIDTH];
            fix_lo_c = prod_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state_q == FIX);
            if (accept_c) begin
                cnt_q    <= '0;
                acc_q    <= ACC_W'(mag_a_c);
                opb_q    <= mag_b_c;
                sign_a_q <= signed_op_c & srca[WIDTH-1];
                sign_b_q <= signed_op_c & srcb[WIDTH-1];
                is_div_q <= DIV_EN & div_op_c;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_next_c;
            end
            if (state_q == FIX) begin
                hi <= fix_hi_c;
                lo <= fix_lo_c;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (rd_req | start);

endmodule
